mul_seq: RTL

Sequential shift-add multiplier for the CPU's execute stage. It sits directly downstream of the team's ripple-carry adder chain: it accepts two WIDTH-bit operands and iterates one conditional add-and-shift per cycle through a WIDTH-bit adder chain. It returns a 2·WIDTH-bit product to the HI/LO write-back path with a start/done handshake. It stalls the pipeline via `busy` while iterating.

---
 rtl/mul_seq_if.sv | 23 ++
 rtl/mul_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mul_seq_if.sv
// Handshake bundle between the execute stage and the sequential multiplier.
// The master drives the operands and start; the slave returns busy/done/result.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               sign;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, sign, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: one conditional add-and-shift per cycle,
// WIDTH iterations, 2*WIDTH-bit product returned with a start/done handshake.
// Optional feature macro: MUL_SIGNED_EN (honours the sign input by multiplying
// magnitudes and negating the product). Without it every operation is unsigned.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  mul_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic               busy_r;
  logic               done_r;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic [2*WIDTH-1:0] result_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH:0]     acc_r;
  logic [CW-1:0]      count_r;

  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] result_nxt_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic               last_s;
  logic               accept_s;

`ifdef MUL_SIGNED_EN
  logic               neg_r;
  logic               neg_s;
`endif

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

  // Datapath combinational terms: operand magnitudes, adder, shifted product.
  always_comb begin
    accept_s = bus.start & (state_r != BUSY);
    last_s   = (count_r == CW'(WIDTH - 1));
    addend_s = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
    // acc never exceeds WIDTH bits before the add, so the carry lands in sum_s[WIDTH].
    sum_s    = acc_r + {1'b0, addend_s};
    // Product after this iteration's shift: {carry, sum, mplier} >> 1, low 2*WIDTH bits.
    prod_s   = {sum_s, mplier_r[WIDTH-1:1]};
`ifdef MUL_SIGNED_EN
    mag_a_s      = (bus.sign & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b_s      = (bus.sign & bus.b[WIDTH-1]) ? -bus.b : bus.b;
    neg_s        = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    result_nxt_s = neg_r ? -prod_s : prod_s;
`else
    mag_a_s      = bus.a;
    mag_b_s      = bus.b;
    result_nxt_s = prod_s;
`endif
  end

  // State register plus registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state decode; start is only looked at outside BUSY.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = bus.start ? BUSY : IDLE;
      BUSY:    next_state_s = last_s ? DONE : BUSY;
      DONE:    next_state_s = bus.start ? BUSY : IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done come straight from flops.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      BUSY:    busy_nxt_s = 1'b1;
      DONE:    done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Operand capture, shift-add iteration and result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= {(2*WIDTH){1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(WIDTH+1){1'b0}};
      count_r  <= {CW{1'b0}};
`ifdef MUL_SIGNED_EN
      neg_r    <= 1'b0;
`endif
    end else if (accept_s) begin
      mcand_r  <= mag_a_s;
      mplier_r <= mag_b_s;
      acc_r    <= {(WIDTH+1){1'b0}};
      count_r  <= {CW{1'b0}};
`ifdef MUL_SIGNED_EN
      neg_r    <= neg_s;
`endif
    end else if (state_r == BUSY) begin
      acc_r    <= {1'b0, sum_s[WIDTH:1]};
      mplier_r <= {sum_s[0], mplier_r[WIDTH-1:1]};
      count_r  <= count_r + CW'(1);
      if (last_s) begin
        result_r <= result_nxt_s;
      end else begin
        result_r <= result_r;
      end
    end else begin
      result_r <= result_r;
    end
  end

endmodule
